seg7_scan_driver: RTL

Parametrised, time-multiplexed seven-segment display driver: latches DIGITS hex nibbles plus per-digit decimal-point, blank and blink flags, then scans them one digit at a time onto a shared segment bus with one digit-enable per digit. It generalises the single-digit combinational decoder into a multi-digit clocked block with a hex font, configurable output polarity, tear-free updates and blinking. It sits between the datapath/result registers and the board display pins.

---
 rtl/seg7_scan_driver_pkg.sv | 53 +++++
 rtl/seg7_hex_font.sv | 18 +
 rtl/seg7_scan_driver.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver_pkg
//   Shared definitions for the multiplexed seven-segment driver:
//     - segment bit positions (seg[0]=a ... seg[6]=g)
//     - 16-entry hex font as lit patterns (1 = segment on, no polarity)
//     - blink phase encoding
//     - small width helper for counters
// ----------------------------------------------------------------------------
package seg7_scan_driver_pkg;

    // Segment bit positions inside a 7-bit pattern.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Lit pattern per hex digit, entry [n] is the glyph for nibble n.
    // Bit order is g f e d c b a (MSB..LSB).
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71,  // F : a e f g
        7'h79,  // E : a d e f g
        7'h5E,  // d : b c d e g
        7'h39,  // C : a d e f
        7'h7C,  // b : c d e f g
        7'h77,  // A : a b c e f g
        7'h6F,  // 9 : a b c d f g
        7'h7F,  // 8 : all
        7'h07,  // 7 : a b c
        7'h7D,  // 6 : a c d e f g
        7'h6D,  // 5 : a c d f g
        7'h66,  // 4 : b c f g
        7'h4F,  // 3 : a b c d g
        7'h5B,  // 2 : a b d e g
        7'h06,  // 1 : b c
        7'h3F   // 0 : a b c d e f
    };

    // Blink phase: digits flagged for blink go dark while in PH_DARK.
    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_DARK    = 1'b1
    } blink_phase_e;

    // Counter width for a modulus of n states; never narrower than one bit
    // so a modulus of 1 still yields a legal (constant-zero) register.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : seg7_scan_driver_pkg

// File: rtl/seg7_hex_font.sv
// ----------------------------------------------------------------------------
// seg7_hex_font
//   Combinational hex-to-seven-segment decoder. Produces the lit pattern only;
//   output polarity is handled by the caller.
//   Ports:
//     nibble_i  in  4  hex digit 0..F
//     lit_o     out 7  lit segments, lit_o[0]=a ... lit_o[6]=g
// ----------------------------------------------------------------------------
module seg7_hex_font
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] lit_o
);

    assign lit_o = HEX_FONT[nibble_i];

endmodule : seg7_hex_font

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for DIGITS seven-segment digits sharing one
//   segment bus. A load strobe captures a pending register set; the active set
//   that feeds the display only changes at a frame boundary so a frame never
//   shows a mix of old and new digits. Digits can be blanked, given a decimal
//   point, or blinked at a rate of BLINK_FRAMES frames per half-period.
//
//   Parameters:
//     DIGITS         number of digits scanned (>= 1)
//     DIV            clock cycles each digit stays enabled (>= 1)
//     BLINK_FRAMES   frames per blink half-period (>= 1)
//     SEG_ACTIVE_LOW 1 = lit segment / dp driven low
//     DIG_ACTIVE_LOW 1 = enabled digit driven low
//   Ports:
//     clk     in   1         rising-edge clock
//     rst_n   in   1         asynchronous active-low reset
//     load    in   1         capture value/dp/blank/blink into pending set
//     value   in   4*DIGITS  nibble i = value[4i+3:4i], digit 0 rightmost
//     dp      in   DIGITS    decimal point lit for digit i
//     blank   in   DIGITS    digit i fully dark
//     blink   in   DIGITS    digit i dark during the blink-off phase
//     seg     out  7         segment bus, seg[0]=a ... seg[6]=g
//     seg_dp  out  1         decimal point
//     dig_en  out  DIGITS    one-hot digit enable
//     frame   out  1         pulse in the last display cycle of digit DIGITS-1
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame
);

    localparam int PW = cnt_width(DIV);
    localparam int IW = cnt_width(DIGITS);
    localparam int FW = cnt_width(BLINK_FRAMES);

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]          cnt_q,   cnt_d;
    logic [IW-1:0]          idx_q,   idx_d;
    logic [FW-1:0]          fcnt_q,  fcnt_d;
    blink_phase_e           phase_q, phase_d;

    logic [4*DIGITS-1:0]    pend_val_q,   pend_val_d;
    logic [DIGITS-1:0]      pend_dp_q,    pend_dp_d;
    logic [DIGITS-1:0]      pend_blank_q, pend_blank_d;
    logic [DIGITS-1:0]      pend_blink_q, pend_blink_d;

    logic [4*DIGITS-1:0]    act_val_q,    act_val_d;
    logic [DIGITS-1:0]      act_dp_q,     act_dp_d;
    logic [DIGITS-1:0]      act_blank_q,  act_blank_d;
    logic [DIGITS-1:0]      act_blink_q,  act_blink_d;

    logic [6:0]             seg_q,    seg_d;
    logic                   seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0]      dig_en_q, dig_en_d;
    logic                   frame_q,  frame_d;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic tick;       // last cycle of the current digit slot
    logic wrap;       // last cycle of the last digit slot = frame boundary

    assign tick = (cnt_q == PRE_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    // ------------------------------------------------------------------
    // Current digit decode (from the active set, before polarity)
    // ------------------------------------------------------------------
    logic [3:0]        cur_nib;
    logic [6:0]        cur_lit;
    logic              cur_dark;
    logic [DIGITS-1:0] cur_onehot;

    assign cur_nib  = act_val_q[4*int'(idx_q) +: 4];
    assign cur_dark = act_blank_q[idx_q] |
                      (act_blink_q[idx_q] & (phase_q == PH_DARK));

    seg7_hex_font u_font (
        .nibble_i (cur_nib),
        .lit_o    (cur_lit)
    );

    always_comb begin
        cur_onehot         = '0;
        cur_onehot[idx_q]  = 1'b1;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Prescaler / digit index / blink counters
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (wrap) begin
            if (fcnt_q == FRM_LAST) begin
                fcnt_d  = '0;
                phase_d = (phase_q == PH_VISIBLE) ? PH_DARK : PH_VISIBLE;
            end else begin
                fcnt_d  = fcnt_q + 1'b1;
            end
        end

        // Pending set: last load wins
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_blink_d = pend_blink_q;
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp;
            pend_blank_d = blank;
            pend_blink_d = blink;
        end

        // Active set only moves at the frame boundary; taking the *_d of the
        // pending set gives the bypass when load lands on that same cycle.
        act_val_d   = act_val_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        act_blink_d = act_blink_q;
        if (wrap) begin
            act_val_d   = pend_val_d;
            act_dp_d    = pend_dp_d;
            act_blank_d = pend_blank_d;
            act_blink_d = pend_blink_d;
        end

        // Output registers: polarity applied last
        seg_d    = (cur_dark ? 7'h00 : cur_lit) ^ SEG_OFF;
        seg_dp_d = (cur_dark ? 1'b0 : act_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
        dig_en_d = cur_onehot ^ DIG_OFF;
        // Registered alongside the display, so it lines up with the final
        // displayed cycle of digit DIGITS-1.
        frame_d  = wrap;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            fcnt_q       <= '0;
            phase_q      <= PH_VISIBLE;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_blink_q <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            act_blink_q  <= '0;
            seg_q        <= SEG_OFF;
            seg_dp_q     <= SEG_ACTIVE_LOW;
            dig_en_q     <= DIG_OFF;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            phase_q      <= phase_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_blink_q <= pend_blink_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_blink_q  <= act_blink_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            dig_en_q     <= dig_en_d;
            frame_q      <= frame_d;
        end
    end

    assign seg    = seg_q;
    assign seg_dp = seg_dp_q;
    assign dig_en = dig_en_q;
    assign frame  = frame_q;

endmodule : seg7_scan_driver
